// File: rtl/dmem_pkg.sv
// Shared encodings for the wait-state data memory (dmem_wait) and its lane aligner.
package dmem_pkg;

    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Reserved size 2'b11 behaves as a word access.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return a[0];
            default: return a != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store lane enables/replicated data and load extract/extend.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [1:0]  a_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wrep_o,
    output logic [31:0] rext_o
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        byte_c = 8'(rword_i >> {a_i, 3'b000});
        half_c = a_i[1] ? rword_i[31:16] : rword_i[15:0];
        be_o   = 4'b1111;
        wrep_o = wdata_i;
        rext_o = rword_i;
        case (size_i)
            SZ_BYTE: begin
                be_o   = 4'(4'b0001 << a_i);
                wrep_o = {4{wdata_i[7:0]}};
                rext_o = uns_i ? {24'h0, byte_c} : {{24{byte_c[7]}}, byte_c};
            end
            SZ_HALF: begin
                be_o   = a_i[1] ? 4'b1100 : 4'b0011;
                wrep_o = {2{wdata_i[15:0]}};
                rext_o = uns_i ? {16'h0, half_c} : {{16{half_c[15]}}, half_c};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_wait.sv
// Data memory with configurable depth and wait states, sized loads/stores and a busy stall handshake.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_wait
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter int unsigned WAIT       = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        misalign
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    we_q;
    logic [1:0]              size_q;
    logic                    uns_q;
    logic [DEPTH_LOG2+1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic [31:0]             rdata_q;
    logic                    done_q;
    logic                    mis_q;
    logic [31:0]             mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0]   idx_c;
    logic [31:0]             rword_c;
    logic [3:0]              be_c;
    logic [31:0]             wrep_c;
    logic [31:0]             rext_c;
    logic [31:0]             merged_c;
    logic                    access_c;
    logic                    bad_c;
    logic                    wr_en_c;
    logic                    unused_addr_c;

    // Upper address bits alias modulo depth.
    assign unused_addr_c = ^addr[31:DEPTH_LOG2+2];

    assign idx_c   = addr_q[DEPTH_LOG2+1:2];
    assign rword_c = mem_q[idx_c];

    dmem_lane_align u_align (
        .size_i  (size_q),
        .uns_i   (uns_q),
        .a_i     (addr_q[1:0]),
        .wdata_i (wdata_q),
        .rword_i (rword_c),
        .be_o    (be_c),
        .wrep_o  (wrep_c),
        .rext_o  (rext_c)
    );

`ifdef DMEM_MISALIGN_TRAP_EN
    assign bad_c = misaligned(size_q, addr_q[1:0]);
`else
    assign bad_c = 1'b0;
`endif

    assign access_c = (state_q == ST_BUSY) && (cnt_q == '0);
    assign wr_en_c  = access_c && we_q && !bad_c && !reset;

    always_comb begin
        merged_c = rword_c;
        for (int l = 0; l < 4; l++) begin
            if (be_c[l]) merged_c[8*l +: 8] = wrep_c[8*l +: 8];
        end
    end

    // Contents are deliberately left uninitialised across reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) mem_q[idx_c] <= merged_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            mis_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // The done cycle belongs to the request just completed.
                    if (req && !done_q) begin
                        we_q    <= we;
                        size_q  <= size;
                        uns_q   <= uns;
                        addr_q  <= addr[DEPTH_LOG2+1:0];
                        wdata_q <= wdata;
                        cnt_q   <= CNT_W'(WAIT);
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                        mis_q   <= bad_c;
                        if (bad_c)      rdata_q <= '0;
                        else if (!we_q) rdata_q <= rext_c;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy     = ((state_q == ST_IDLE) && req && !done_q) || (state_q == ST_BUSY);
    assign rdata    = rdata_q;
    assign done     = done_q;
    assign misalign = mis_q;

endmodule

// File: tb/tb_dmem_wait.sv
// Directed self-checking bench for dmem_wait; three instances cover WAIT=1, WAIT=0 and WAIT=3.
module tb_dmem_wait;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req, we, uns;
    logic [1:0]  size  [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic [2:0]  busy, done, misalign;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_wait #(.DEPTH_LOG2(6), .WAIT(1)) u_w1 (
        .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .size(size[0]), .uns(uns[0]),
        .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .busy(busy[0]), .done(done[0]),
        .misalign(misalign[0]));

    dmem_wait #(.DEPTH_LOG2(6), .WAIT(0)) u_w0 (
        .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .size(size[1]), .uns(uns[1]),
        .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .busy(busy[1]), .done(done[1]),
        .misalign(misalign[1]));

    dmem_wait #(.DEPTH_LOG2(6), .WAIT(3)) u_w3 (
        .clk(clk), .reset(reset), .req(req[2]), .we(we[2]), .size(size[2]), .uns(uns[2]),
        .addr(addr[2]), .wdata(wdata[2]), .rdata(rdata[2]), .busy(busy[2]), .done(done[2]),
        .misalign(misalign[2]));

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access on instance k starting in an idle cycle; checks latency and busy span.
    task automatic acc(input int k, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic mis);
        int wt;
        int busy_n;
        int lat;
        bit seen;
        wt = (k == 0) ? 1 : ((k == 1) ? 0 : 3);
        req[k] = 1'b1; we[k] = w; size[k] = sz; uns[k] = u; addr[k] = a; wdata[k] = d;
        #1;
        busy_n = busy[k] ? 1 : 0;
        seen = 1'b0; lat = 0; rd = '0; mis = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            nxt();
            req[k] = 1'b0;
            #1;
            if (done[k]) begin
                seen = 1'b1; lat = c; rd = rdata[k]; mis = misalign[k];
            end
            if (busy[k]) busy_n++;
        end
        chk($sformatf("k%0d_a%h_done_seen", k, a), 32'(seen), 32'd1);
        chk($sformatf("k%0d_a%h_latency", k, a), 32'(lat), 32'(wt + 2));
        chk($sformatf("k%0d_a%h_busy_cycles", k, a), 32'(busy_n), 32'(wt + 2));
        nxt();
    endtask

    logic [31:0] rd;
    logic        mis;
    logic [5:0]  exp_done;
    logic [5:0]  exp_busy;

    initial begin
        reset = 1'b1;
        req = '0; we = '0; uns = '0;
        for (int i = 0; i < 3; i++) begin
            size[i] = SZ_WORD; addr[i] = '0; wdata[i] = '0;
        end
        nxt();
        nxt();
        chk("rst_rdata", rdata[0], 32'h0);
        chk("rst_busy", 32'(busy[0]), 32'h0);
        chk("rst_done", 32'(done[0]), 32'h0);
        chk("rst_misalign", 32'(misalign[0]), 32'h0);
        reset = 1'b0;
        nxt();

        // Word store then load, WAIT=1
        acc(0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, rd, mis);
        chk("sw10_rdata_kept", rd, 32'h0);
        acc(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd, mis);
        chk("lw10", rd, 32'hDEADBEEF);

        // Byte store and extension
        acc(0, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h11223344, rd, mis);
        chk("sw20_rdata_kept", rd, 32'hDEADBEEF);
        acc(0, 1'b1, SZ_BYTE, 1'b0, 32'h22, 32'hAABBCC80, rd, mis);
        acc(0, 1'b0, SZ_BYTE, 1'b0, 32'h22, 32'h0, rd, mis);
        chk("lb22", rd, 32'hFFFFFF80);
        acc(0, 1'b0, SZ_BYTE, 1'b1, 32'h22, 32'h0, rd, mis);
        chk("lbu22", rd, 32'h00000080);
        acc(0, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, rd, mis);
        chk("lw20", rd, 32'h11803344);

        // Half store through an aliased address
        acc(0, 1'b1, SZ_HALF, 1'b0, 32'h102, 32'h1234BEEF, rd, mis);
        acc(0, 1'b0, SZ_HALF, 1'b0, 32'h02, 32'h0, rd, mis);
        chk("lh02", rd, 32'hFFFFBEEF);
        acc(0, 1'b0, SZ_HALF, 1'b1, 32'h02, 32'h0, rd, mis);
        chk("lhu02", rd, 32'h0000BEEF);

        // Request held high for six cycles, WAIT=0
        exp_done = 6'b100100;
        exp_busy = 6'b011011;
        req[1] = 1'b1; we[1] = 1'b1; size[1] = SZ_WORD; uns[1] = 1'b0;
        addr[1] = 32'h40; wdata[1] = 32'hA5A5A5A5;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("held_done_c%0d", i), 32'(done[1]), 32'(exp_done[i]));
            chk($sformatf("held_busy_c%0d", i), 32'(busy[1]), 32'(exp_busy[i]));
            nxt();
        end
        req[1] = 1'b0;
        #1;
        chk("held_after_busy", 32'(busy[1]), 32'h0);
        chk("held_after_done", 32'(done[1]), 32'h0);
        nxt();
        acc(1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, rd, mis);
        chk("held_lw40", rd, 32'hA5A5A5A5);

        // Reset in the second BUSY cycle, WAIT=3
        acc(2, 1'b1, SZ_WORD, 1'b0, 32'h30, 32'h00000000, rd, mis);
        acc(2, 1'b1, SZ_WORD, 1'b0, 32'h34, 32'h12345678, rd, mis);
        acc(2, 1'b0, SZ_WORD, 1'b0, 32'h34, 32'h0, rd, mis);
        chk("w3_lw34", rd, 32'h12345678);
        req[2] = 1'b1; we[2] = 1'b1; size[2] = SZ_WORD; addr[2] = 32'h30; wdata[2] = 32'h5555AAAA;
        #1;
        chk("rstmid_busy_t0", 32'(busy[2]), 32'h1);
        nxt();
        req[2] = 1'b0;
        #1;
        chk("rstmid_busy_t1", 32'(busy[2]), 32'h1);
        nxt();
        reset = 1'b1;
        #1;
        chk("rstmid_busy_t2", 32'(busy[2]), 32'h1);
        nxt();
        #1;
        chk("rstmid_busy_after", 32'(busy[2]), 32'h0);
        chk("rstmid_done_after", 32'(done[2]), 32'h0);
        chk("rstmid_rdata_after", rdata[2], 32'h0);
        reset = 1'b0;
        nxt();
        acc(2, 1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, rd, mis);
        chk("rstmid_lw30", rd, 32'h00000000);

        // Misaligned word store
        acc(0, 1'b1, SZ_WORD, 1'b0, 32'h30, 32'hCAFEF00D, rd, mis);
        acc(0, 1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, rd, mis);
        chk("mis_pre_lw30", rd, 32'hCAFEF00D);
        acc(0, 1'b1, SZ_WORD, 1'b0, 32'h31, 32'h99999999, rd, mis);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("mis_sw31_flag", 32'(mis), 32'h1);
        chk("mis_sw31_rdata", rd, 32'h0);
        acc(0, 1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, rd, mis);
        chk("mis_post_lw30", rd, 32'hCAFEF00D);
`else
        chk("mis_sw31_flag", 32'(mis), 32'h0);
        chk("mis_sw31_rdata", rd, 32'hCAFEF00D);
        acc(0, 1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, rd, mis);
        chk("mis_post_lw30", rd, 32'h99999999);
`endif
        chk("mis_post_flag", 32'(mis), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
